lsu_ctrl: RTL and testbench

//  Load/store sequencer between the MEM stage and a handshaked data memory.
//  - Accepts one load/store per instruction and stalls the pipeline until memory acks.
//  - Aligns the returned word by address and applies byte/half, signed/unsigned extension.
//  - Drives byte-lane masks for stores.
//  - Flags misaligned accesses and bus timeouts.

---
 rtl/lsu_ctrl.sv | 154 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the MEM stage and a handshaked data memory.
// Aligns and extends load data, builds store byte lanes, flags misalignment and ack timeouts.
module lsu_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_sl_sel,
    output logic        o_stall,
    output logic        o_ld_valid,
    output logic [31:0] o_ld_data,
    output logic        o_misalign,
    output logic        o_bus_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [2:0] SEL_B  = 3'b001;
    localparam logic [2:0] SEL_H  = 3'b010;
    localparam logic [2:0] SEL_W  = 3'b011;
    localparam logic [2:0] SEL_BU = 3'b100;
    localparam logic [2:0] SEL_HU = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       sel_p0;
    logic [1:0]       off_p0;
    logic             legal;
    logic             misaligned;
    logic             accept;

    function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                                input logic [1:0]  off,
                                                input logic [2:0]  sel);
        logic [31:0]        sh;
        logic signed [7:0]  sb;
        logic signed [15:0] shw;
        sh  = rdata >> {off, 3'b000};
        sb  = sh[7:0];
        shw = sh[15:0];
        case (sel)
            SEL_B:   return 32'(sb);
            SEL_BU:  return {24'd0, sh[7:0]};
            SEL_H:   return 32'(shw);
            SEL_HU:  return {16'd0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] sel,
                                              input logic [1:0] off,
                                              input logic       we);
        if (!we) return 4'hF;
        case (sel)
            SEL_B:   return 4'b0001 << off;
            SEL_H:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0]  sel,
                                               input logic [31:0] d);
        case (sel)
            SEL_B:   return {4{d[7:0]}};
            SEL_H:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        case (i_sl_sel)
            SEL_B:  legal = 1'b1;
            SEL_H:  begin legal = 1'b1;  misaligned = i_addr[0];    end
            SEL_W:  begin legal = 1'b1;  misaligned = |i_addr[1:0]; end
            SEL_BU: legal = !i_we;
            SEL_HU: begin legal = !i_we; misaligned = i_addr[0];    end
            default: legal = 1'b0;
        endcase
    end

    // Reset gates the combinational handshake so nothing leaks out while it is held.
    assign accept     = (state == S_IDLE) && i_req && legal && !misaligned && !i_reset;
    assign o_misalign = (state == S_IDLE) && i_req && legal && misaligned && !i_reset;
    assign o_stall    = accept || (state == S_ACCESS);
    assign o_mem_req  = (state == S_ACCESS);

    // Accept stage: operand bookkeeping needed only to format the returned word.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            sel_p0 <= i_sl_sel;
            off_p0 <= i_addr[1:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            o_ld_valid  <= 1'b0;
            o_ld_data   <= '0;
            o_bus_err   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_bmask <= '0;
        end else begin
            o_ld_valid <= 1'b0;
            o_ld_data  <= '0;
            o_bus_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        o_mem_we    <= i_we;
                        o_mem_addr  <= {i_addr[31:2], 2'b00};
                        o_mem_wdata <= store_data(i_sl_sel, i_wdata);
                        o_mem_bmask <= store_mask(i_sl_sel, i_addr[1:0], i_we);
                        cnt         <= '0;
                        state       <= S_ACCESS;
                    end
                end
                // Access stage: ack takes priority over the timeout on the final cycle.
                S_ACCESS: begin
                    if (i_mem_ack) begin
                        if (!o_mem_we) begin
                            o_ld_valid <= 1'b1;
                            o_ld_data  <= load_extend(i_mem_rdata, off_p0, sel_p0);
                        end
                        state <= S_RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        o_bus_err <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: randomized load/store traffic against a
// transaction-level model, plus directed literal cases for known answers.
module tb_lsu_ctrl;
    localparam int TIMEOUT = 64;

    logic        i_clk = 1'b0;
    logic        i_reset, i_req, i_we, i_mem_ack;
    logic [31:0] i_addr, i_wdata, i_mem_rdata;
    logic [2:0]  i_sl_sel;
    logic        o_stall, o_ld_valid, o_misalign, o_bus_err, o_mem_req, o_mem_we;
    logic [31:0] o_ld_data, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_bmask;

    always #5 i_clk = ~i_clk;

    lsu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_we(i_we),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_sl_sel(i_sl_sel),
        .o_stall(o_stall), .o_ld_valid(o_ld_valid), .o_ld_data(o_ld_data),
        .o_misalign(o_misalign), .o_bus_err(o_bus_err), .o_mem_req(o_mem_req),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_bmask(o_mem_bmask), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs for the current cycle, written by the driver.
    logic        e_stall, e_misalign, e_ld_valid, e_bus_err, e_mem_req;
    logic [31:0] e_ld_data;
    logic        e_mem_chk, e_wdata_chk, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_bmask;

    // Observations gathered per transaction by the compare process.
    int          cyc = 0;
    int          stall_cnt, ldv_cnt, mis_cnt, req_cnt, err_idx;
    logic [31:0] last_ld, last_maddr, last_wdata;
    logic [3:0]  last_bmask;
    logic        last_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        #2;
        chk("stall",    32'(o_stall),    32'(e_stall));
        chk("misalign", 32'(o_misalign), 32'(e_misalign));
        chk("ld_valid", 32'(o_ld_valid), 32'(e_ld_valid));
        chk("ld_data",  o_ld_data,       e_ld_data);
        chk("bus_err",  32'(o_bus_err),  32'(e_bus_err));
        chk("mem_req",  32'(o_mem_req),  32'(e_mem_req));
        if (e_mem_chk) begin
            chk("mem_we",    32'(o_mem_we),    32'(e_we));
            chk("mem_addr",  o_mem_addr,       e_addr);
            chk("mem_bmask", 32'(o_mem_bmask), 32'(e_bmask));
            if (e_wdata_chk) chk("mem_wdata", o_mem_wdata, e_wdata);
        end
        stall_cnt += int'(o_stall);
        ldv_cnt   += int'(o_ld_valid);
        mis_cnt   += int'(o_misalign);
        req_cnt   += int'(o_mem_req);
        if (o_ld_valid) last_ld = o_ld_data;
        if (o_bus_err) err_idx = cyc;
        if (o_mem_req) begin
            last_maddr = o_mem_addr;
            last_wdata = o_mem_wdata;
            last_bmask = o_mem_bmask;
            last_we    = o_mem_we;
        end
        cyc++;
    end

    task automatic drive_slot();
        @(negedge i_clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic noise_ack();
        i_mem_ack   = ($urandom_range(0, 3) == 0);
        i_mem_rdata = $urandom;
    endtask

    task automatic exp_quiet();
        e_stall = 0; e_misalign = 0; e_ld_valid = 0; e_ld_data = '0; e_bus_err = 0;
        e_mem_req = 0; e_mem_chk = 0; e_wdata_chk = 0;
        e_we = 0; e_addr = '0; e_wdata = '0; e_bmask = '0;
    endtask

    task automatic clear_obs();
        stall_cnt = 0; ldv_cnt = 0; mis_cnt = 0; req_cnt = 0; err_idx = -1;
        last_ld = '0; last_maddr = '0; last_wdata = '0; last_bmask = '0; last_we = 0;
    endtask

    function automatic int access_size(input logic [2:0] sel);
        if (sel == 3'd1 || sel == 3'd4) return 1;
        if (sel == 3'd2 || sel == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic is_legal(input logic [2:0] sel, input logic we);
        return (sel >= 3'd1 && sel <= 3'd3) || ((sel == 3'd4 || sel == 3'd5) && !we);
    endfunction

    task automatic idle_cycle();
        drive_slot();
        i_sl_sel = 3'($urandom_range(0, 7));
        i_we     = 1'($urandom_range(0, 1));
        i_addr   = $urandom;
        i_wdata  = $urandom;
        i_req    = is_legal(i_sl_sel, i_we) ? 1'b0 : 1'($urandom_range(0, 1));
        noise_ack();
        exp_quiet();
        settle();
    endtask

    // Drives one instruction from acceptance through its response cycle.
    // wait_n = number of ACCESS cycles before ack; >= TIMEOUT means never.
    task automatic run_txn(input logic we, input logic [2:0] sel, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int wait_n, output int acc_idx);
        int          size, n, off, m;
        logic        legal, mis, ok;
        logic [63:0] p;
        logic [31:0] ld, wd;
        logic [3:0]  mask;
        size  = access_size(sel);
        off   = int'(addr[1:0]);
        legal = is_legal(sel, we);
        mis   = (off % size) != 0;
        p = {32'd0, rdata} >> (8 * off);
        p = p & ((64'd1 << (8 * size)) - 64'd1);
        if ((sel == 3'd1 || sel == 3'd2) && p[8*size-1]) p = p - (64'd1 << (8 * size));
        ld = p[31:0];
        m    = ((1 << size) - 1) << off;
        mask = m[3:0];
        wd   = (size == 1) ? {24'd0, wdata[7:0]} * 32'h0101_0101 :
               (size == 2) ? {16'd0, wdata[15:0]} * 32'h0001_0001 : wdata;
        clear_obs();
        drive_slot();
        acc_idx = cyc;
        i_req = 1; i_we = we; i_sl_sel = sel; i_addr = addr; i_wdata = wdata;
        noise_ack();
        exp_quiet();
        e_misalign = legal && mis;
        e_stall    = legal && !mis;
        settle();
        if (!(legal && !mis)) return;
        n = (wait_n < TIMEOUT) ? wait_n + 1 : TIMEOUT;
        for (int k = 0; k < n; k++) begin
            drive_slot();
            i_mem_ack   = (k == wait_n);
            i_mem_rdata = (k == wait_n) ? rdata : $urandom;
            exp_quiet();
            e_stall = 1; e_mem_req = 1; e_mem_chk = 1;
            e_we = we; e_addr = addr & 32'hFFFF_FFFC;
            e_bmask = we ? mask : 4'hF;
            e_wdata = wd; e_wdata_chk = we;
            settle();
        end
        ok = wait_n < TIMEOUT;
        drive_slot();
        noise_ack();
        exp_quiet();
        e_ld_valid = ok && !we;
        e_ld_data  = (ok && !we) ? ld : 32'd0;
        e_bus_err  = !ok;
        settle();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, r, w;
        i_reset = 1; i_req = 0; i_we = 0; i_addr = '0; i_wdata = '0; i_sl_sel = '0;
        i_mem_ack = 0; i_mem_rdata = '0;
        exp_quiet();
        e_mem_chk = 1; e_wdata_chk = 1;
        clear_obs();
        repeat (2) begin drive_slot(); settle(); end
        drive_slot(); i_reset = 0; exp_quiet(); settle();

        // Directed cases with hand-computed answers.
        run_txn(0, 3'b001, 32'h103, 32'h0, 32'h80AA55CC, 0, acc);
        chk("lb_data", last_ld, 32'hFFFFFF80);
        chk("lb_stall_cycles", 32'(stall_cnt), 32'd2);
        chk("lb_valid_pulses", 32'(ldv_cnt), 32'd1);

        run_txn(0, 3'b101, 32'h202, 32'h0, 32'h9ABC1234, 3, acc);
        chk("lhu_mem_addr", last_maddr, 32'h200);
        chk("lhu_data", last_ld, 32'h00009ABC);
        chk("lhu_stall_cycles", 32'(stall_cnt), 32'd5);

        run_txn(1, 3'b001, 32'h301, 32'h000000EE, 32'h0, 1, acc);
        chk("sb_bmask", 32'(last_bmask), 32'h2);
        chk("sb_wdata", last_wdata, 32'hEEEEEEEE);
        chk("sb_we", 32'(last_we), 32'd1);
        chk("sb_no_ld_valid", 32'(ldv_cnt), 32'd0);

        run_txn(0, 3'b011, 32'h402, 32'h0, 32'h0, 0, acc);
        chk("lw_mis_pulses", 32'(mis_cnt), 32'd1);
        chk("lw_mis_req", 32'(req_cnt), 32'd0);
        chk("lw_mis_stall", 32'(stall_cnt), 32'd0);

        run_txn(0, 3'b011, 32'h600, 32'h0, 32'h12345678, 1000, acc);
        chk("timeout_err_cycle", 32'(err_idx - acc), 32'd65);
        chk("timeout_stall_cycles", 32'(stall_cnt), 32'd65);
        chk("timeout_no_ld_valid", 32'(ldv_cnt), 32'd0);

        run_txn(0, 3'b011, 32'h700, 32'h0, 32'hCAFEF00D, TIMEOUT - 1, acc);
        chk("late_ack_data", last_ld, 32'hCAFEF00D);
        chk("late_ack_no_err", 32'(err_idx), 32'hFFFFFFFF);

        // Reset during the second ACCESS cycle.
        drive_slot();
        i_req = 1; i_we = 0; i_sl_sel = 3'b011; i_addr = 32'h500; i_mem_ack = 0;
        exp_quiet(); e_stall = 1;
        settle();
        drive_slot();
        i_mem_ack = 0;
        exp_quiet(); e_stall = 1; e_mem_req = 1; e_mem_chk = 1; e_addr = 32'h500; e_bmask = 4'hF;
        settle();
        drive_slot();
        i_reset = 1;
        exp_quiet(); e_mem_chk = 1; e_wdata_chk = 1;
        settle();
        drive_slot();
        i_req = 0;
        settle();
        drive_slot();
        i_reset = 0;
        exp_quiet();
        settle();
        run_txn(0, 3'b011, 32'h504, 32'h0, 32'h0BADBEEF, 1, acc);
        chk("post_reset_lw", last_ld, 32'h0BADBEEF);
        chk("post_reset_valid", 32'(ldv_cnt), 32'd1);

        // Randomized traffic, back-to-back or with short gaps.
        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 19);
            if (r < 14)      w = $urandom_range(0, 4);
            else if (r < 16) w = $urandom_range(5, 10);
            else if (r < 18) w = TIMEOUT - 1;
            else             w = 1000;
            run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                    $urandom, $urandom, w, acc);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        drive_slot();
        i_req = 0;
        exp_quiet();
        settle();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
